// File: rtl/irrigation_display_pkg.sv
// irrigation_display_pkg: shared widths, condition encoding and 7-segment glyphs
// Segment vectors are {g,f,e,d,c,b,a} in active-high form, bit0 = a.
package irrigation_display_pkg;

    localparam int SEG_W = 7;

    typedef enum logic [1:0] {
        COND_OFF       = 2'b00,
        COND_DRIP      = 2'b01,
        COND_SPRINKLER = 2'b10,
        COND_FAULT     = 2'b11
    } cond_e;

    localparam logic [SEG_W-1:0] GLYPH_OFF       = 7'b1000000;
    localparam logic [SEG_W-1:0] GLYPH_DRIP      = 7'b1011110;
    localparam logic [SEG_W-1:0] GLYPH_SPRINKLER = 7'b1101101;
    localparam logic [SEG_W-1:0] GLYPH_FAULT     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_ALL_ON      = 7'h7F;

endpackage

// File: rtl/irrigation_glyph_rom.sv
// irrigation_glyph_rom: combinational channel condition to active-high segment decode
// Ports: cond - channel condition; seg - {g,f,e,d,c,b,a} pattern
module irrigation_glyph_rom
    import irrigation_display_pkg::*;
(
    input  cond_e            cond,
    output logic [SEG_W-1:0] seg
);

    assign seg = cond == COND_OFF       ? GLYPH_OFF :
                 cond == COND_DRIP      ? GLYPH_DRIP :
                 cond == COND_SPRINKLER ? GLYPH_SPRINKLER : GLYPH_FAULT;

endmodule

// File: rtl/irrigation_display_scanner.sv
// irrigation_display_scanner: time-multiplexed 7-segment driver, one digit per irrigation channel
// Ports: clk_i/rst_n_i - clock and async active-low reset; cond_i/alarm_i - per-channel
// condition and alarm, captured into shadows when load_i is high; enable_i - display on;
// lamp_test_i - all segments of the scanned digit on; segments_o/digit_en_o - registered
// display drive (optionally inverted); frame_o - one-cycle pulse when the scan wraps.
module irrigation_display_scanner
    import irrigation_display_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25,
    parameter int ACTIVE_LOW_SEG = 0,
    parameter int ACTIVE_LOW_DIG = 0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [2*NUM_CH-1:0] cond_i,
    input  logic [NUM_CH-1:0]   alarm_i,
    input  logic                load_i,
    input  logic                enable_i,
    input  logic                lamp_test_i,
    output logic [SEG_W-1:0]    segments_o,
    output logic [NUM_CH-1:0]   digit_en_o,
    output logic                frame_o
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [SEG_W-1:0]  SEG_INV = ACTIVE_LOW_SEG != 0 ? '1 : '0;
    localparam logic [NUM_CH-1:0] DIG_INV = ACTIVE_LOW_DIG != 0 ? '1 : '0;

    logic [CW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       fcnt;
    logic                blink;
    logic                frame_q;
    logic                tick;
    logic                wrap;
    logic                blink_flip;
    logic [2*NUM_CH-1:0] sh_cond;
    logic [NUM_CH-1:0]   sh_alarm;
    logic [NUM_CH-1:0]   dig_q;
    logic [NUM_CH-1:0]   dig_d;
    logic [SEG_W-1:0]    seg_q;
    logic [SEG_W-1:0]    seg_d;
    logic [SEG_W-1:0]    glyph;
    cond_e               cur_cond;

    assign tick       = pre == CW'(SCAN_DIV - 1);
    assign wrap       = tick && idx == IW'(NUM_CH - 1);
    assign blink_flip = wrap && fcnt == FW'(BLINK_DIV - 1);
    assign cur_cond   = cond_e'(sh_cond[2*idx +: 2]);

    irrigation_glyph_rom u_rom (
        .cond (cur_cond),
        .seg  (glyph)
    );

    // Next display word is built only from shadows and scan state, so a slot
    // can never show a half-updated channel set.
    always_comb begin
        dig_d = enable_i ? NUM_CH'(1) << idx : '0;
        seg_d = !enable_i                     ? '0 :
                lamp_test_i                   ? SEG_ALL_ON :
                (sh_alarm[idx] && blink)      ? '0 : glyph;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre      <= '0;
            idx      <= '0;
            fcnt     <= '0;
            blink    <= 1'b0;
            frame_q  <= 1'b0;
            sh_cond  <= '0;
            sh_alarm <= '0;
            seg_q    <= '0;
            dig_q    <= '0;
        end else begin
            pre     <= tick ? '0 : pre + 1'b1;
            frame_q <= wrap;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            if (tick)
                idx <= idx == IW'(NUM_CH - 1) ? '0 : idx + 1'b1;
            if (wrap)
                fcnt <= blink_flip ? '0 : fcnt + 1'b1;
            if (blink_flip)
                blink <= ~blink;
            if (load_i) begin
                sh_cond  <= cond_i;
                sh_alarm <= alarm_i;
            end
        end
    end

    // Inverting after the register keeps the reset state "all off" in either polarity.
    assign segments_o = seg_q ^ SEG_INV;
    assign digit_en_o = dig_q ^ DIG_INV;
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_irrigation_display_scanner.sv
// tb_irrigation_display_scanner: directed bench for the scanner with a fast scan configuration
module tb_irrigation_display_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst2_n = 1'b0;
    logic [7:0] cond = 8'h00;
    logic [3:0] alarm = 4'h0;
    logic       load = 1'b0;
    logic       load2 = 1'b0;
    logic       enable = 1'b1;
    logic       lamp = 1'b0;
    logic [6:0] seg;
    logic [3:0] dig;
    logic       frame;
    logic [6:0] seg2;
    logic [3:0] dig2;
    logic       frame2;

    int checks = 0;
    int failures = 0;
    int n = 0;

    always #5 clk = ~clk;

    irrigation_display_scanner #(
        .NUM_CH(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_DIG(0)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cond_i(cond), .alarm_i(alarm), .load_i(load),
        .enable_i(enable), .lamp_test_i(lamp), .segments_o(seg), .digit_en_o(dig),
        .frame_o(frame)
    );

    irrigation_display_scanner #(
        .NUM_CH(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1)
    ) dut_low (
        .clk_i(clk), .rst_n_i(rst2_n), .cond_i(cond), .alarm_i(alarm), .load_i(load2),
        .enable_i(enable), .lamp_test_i(lamp), .segments_o(seg2), .digit_en_o(dig2),
        .frame_o(frame2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at n=%0d: got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    initial begin
        logic [6:0] g1 [4];
        g1 = '{7'h40, 7'h5E, 7'h6D, 7'h79};

        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", seg, 7'h00);
        check("rst_dig", dig, 4'h0);
        check("rst_frame", frame, 1'b0);
        check("rst_seg_low", seg2, 7'h7F);
        check("rst_dig_low", dig2, 4'hF);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        n = 0;

        for (int i = 1; i <= 16; i++) begin
            step();
            check("scan_dig", dig, 32'd1 << ((n - 1) / 4));
            check("scan_seg", seg, 7'h40);
            check("scan_frame", frame, (n == 16) ? 1 : 0);
        end

        cond = 8'b11_10_01_00;
        load = 1'b1;
        step();
        load = 1'b0;
        check("load_first", seg, 7'h40);
        while (n < 32) begin
            step();
            check("load_glyph", seg, g1[((n - 1) / 4) % 4]);
        end

        cond = 8'h00;
        while (n < 80) begin
            step();
            check("noload_hold", seg, g1[((n - 1) / 4) % 4]);
        end

        cond = 8'b00_01_10_11;
        step();
        check("mid_pre1", seg, 7'h40);
        step();
        check("mid_pre2", seg, 7'h40);
        load = 1'b1;
        step();
        load = 1'b0;
        check("mid_load_edge", seg, 7'h40);
        step();
        check("mid_load_next", seg, 7'h79);

        alarm = 4'b0100;
        load = 1'b1;
        step();
        load = 1'b0;
        check("alarm_ch1", seg, 7'h6D);
        run_to(90);
        check("alarm_on_dig", dig, 4'b0100);
        check("alarm_on_seg", seg, 7'h5E);
        run_to(102);
        check("alarm_other", seg, 7'h6D);
        run_to(106);
        check("alarm_off_dig", dig, 4'b0100);
        check("alarm_off_seg", seg, 7'h00);
        run_to(120);
        lamp = 1'b1;
        step();
        check("lamp_seg", seg, 7'h7F);
        check("lamp_dig", dig, 4'b0100);
        lamp = 1'b0;
        step();
        check("lamp_release", seg, 7'h00);
        run_to(138);
        check("alarm_back", seg, 7'h5E);

        run_to(142);
        enable = 1'b0;
        step();
        check("dis_dig", dig, 4'h0);
        check("dis_seg", seg, 7'h00);
        step();
        check("dis_frame", frame, 1'b1);
        step();
        enable = 1'b1;
        step();
        check("reen_dig", dig, 4'b0001);
        check("reen_seg", seg, 7'h79);
        run_to(159);
        check("frame_gap", frame, 1'b0);
        step();
        check("frame_keep", frame, 1'b1);

        check("low_seg_run", seg2, 7'h3F);
        check("low_dig_run", dig2, 4'b0111);
        #2;
        rst2_n = 1'b0;
        #1;
        check("low_rst_seg", seg2, 7'h7F);
        check("low_rst_dig", dig2, 4'hF);
        check("low_rst_frame", frame2, 1'b0);
        step();
        step();
        check("low_hold_seg", seg2, 7'h7F);
        check("low_hold_dig", dig2, 4'hF);
        rst2_n = 1'b1;
        step();
        check("low_rel_seg", seg2, 7'h3F);
        check("low_rel_dig", dig2, 4'b1110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
